interleaver_bank_sched: RTL and testbench
=========================================

// Module: interleaver_bank_sched
// PURPOSE
//  Ping-pong bank scheduler for the turbo interleaver. It shares two interleaver
//  RAM banks between the CRC-side writer and the permuted-read side. It also
//  generates the linear write/read indices, which the external permutation table
//  maps to RAM addresses, and tracks per-bank fill state and block length.
//  Sits between the CRC attach stage and the interleaver RAM/address-ROM datapath.
// PARAMETERS
//  ADDR_W     13    index width; must satisfy 2**ADDR_W >= LARGE_LEN
//  SMALL_LEN  1056  block length (bits) when block_size=0
//  LARGE_LEN  6144  block length (bits) when block_size=1
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high reset
//  block_size  in   1       0=SMALL_LEN, 1=LARGE_LEN; sampled on accepted in_start beat
//  in_start    in   1       marks first beat of a block; only meaningful with in_valid
//  in_valid    in   1       input beat present
//  in_end      in   1       marks last beat of a block (may be early)
//  in_ready    out  1       scheduler can accept a beat this cycle
//  wr_en       out  1       write strobe to RAM bank wr_bank
//  wr_bank     out  1       bank being written
//  wr_idx      out  ADDR_W  linear write index
//  rd_en       out  1       read strobe to RAM bank rd_bank
//  rd_bank     out  1       bank being read
//  rd_idx      out  ADDR_W  linear index to permutation table
//  out_ready   in   1       downstream can take a read beat issued this cycle
//  out_valid   out  1       read data valid; equals rd_en delayed 1 cycle
//  out_last    out  1       with out_valid: final beat of block
//  bank_full   out  2       bit b=1: bank b holds a complete block not yet fully read
//  done        out  1       1-cycle pulse with final out_valid of a block
//  proto_err   out  1       sticky: beat dropped (no start, or no free bank)
// BEHAVIOUR
//  Reset: in_ready=1 and all other outputs=0; both banks EMPTY; wr_bank=0, rd_bank=0.
//  A reset mid-block discards all bank contents and lengths.
//  Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. A bank is never
//  written and read in the same cycle.
//  Writer FSM:
//   W_IDLE: in_ready=1 iff an EMPTY bank exists.
//    - Accepted beat with in_start: select the lowest EMPTY bank (ties resolve to
//      the bank after the last one written), latch its length, write idx 0, enter
//      W_FILL.
//    - Accepted beat without in_start: dropped, proto_err set.
//   W_FILL: in_ready=1. Each accepted beat: wr_en=1, wr_idx=count, count+1.
//    - Block closes when the beat has in_end or count==len-1. The bank goes FULL
//      with stored length=count+1, and the FSM returns to W_IDLE next cycle.
//    - in_start during W_FILL restarts the same bank at idx 0 with a newly sampled
//      block_size. The partial block is discarded.
//  Dropped beats: in_valid while in_ready=0 sets proto_err; the data is lost.
//  wr_en, wr_idx and wr_bank are combinational from the accepted beat
//  (zero latency). Reader indices are registered.
//  Reader FSM:
//   R_IDLE: when any bank is FULL, take the oldest FULL bank (FIFO order) and mark
//    it DRAINING. rd_idx=0. Enter R_READ the next cycle.
//   R_READ: rd_en=out_ready. When rd_en=1, rd_idx increments.
//    - The beat with rd_idx==len-1 is the last read. The bank goes EMPTY in the
//      same cycle, and the FSM goes to R_IDLE.
//    - out_valid, out_last and done follow one cycle later.
//    - out_ready=0 stalls the issue of new reads only. An in-flight beat still
//      presents next cycle.
//  Simultaneous events: writer closing bank A while reader frees bank B in the
//  same cycle are both honoured. A freed bank is eligible for in_start next cycle.
//  Throughput: back-to-back blocks at one beat/cycle with no bubble on the write
//  side while the other bank drains. The reader has a 1-cycle R_IDLE gap per block.
//  bank_full[b]=1 for FULL or DRAINING.
// TESTING
//  1) Reset, then 1056 beats (start, block_size=0), out_ready=1: rd_idx 0..1055,
//     out_last and done on the 1056th out_valid; bank_full returns to 00.
//  2) Three back-to-back 6144-bit blocks, out_ready=0 throughout: blocks 1,2 fill
//     banks 0,1; in_ready=0 after 12288 beats; extra beats set proto_err.
//  3) in_end on beat 100 of a large block: stored length 100; reader issues
//     exactly 100 reads, out_last at rd_idx 99.
//  4) in_start re-asserted at beat 500 of a block: wr_idx restarts at 0 in the
//     same bank; reader sees only the restarted block.
//  5) out_ready toggling 1010...: out_valid count equals rd_en count, and
//     out_valid always lags rd_en by exactly 1 cycle.
//  6) reset asserted mid-drain and mid-fill: next cycle bank_full=00,
//     in_ready=1, no rd_en/wr_en, and proto_err cleared.

Source files
------------

// File: rtl/interleaver_bank_sched.sv
// Ping-pong bank scheduler for the turbo interleaver: arbitrates two RAM banks between
// the CRC-side writer and the permuted reader, generating linear write/read indices.
module interleaver_bank_sched #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned SMALL_LEN = 1056,
  parameter int unsigned LARGE_LEN = 6144
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              block_size_i,
  input  logic              in_start_i,
  input  logic              in_valid_i,
  input  logic              in_end_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic              wr_bank_o,
  output logic [ADDR_W-1:0] wr_idx_o,
  output logic              rd_en_o,
  output logic              rd_bank_o,
  output logic [ADDR_W-1:0] rd_idx_o,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic              out_last_o,
  output logic [1:0]        bank_full_o,
  output logic              done_o,
  output logic              proto_err_o
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
  typedef enum logic {W_IDLE, W_FILL} wr_st_e;
  typedef enum logic {R_IDLE, R_READ} rd_st_e;

  localparam logic [ADDR_W-1:0] LEN_S = ADDR_W'(SMALL_LEN);
  localparam logic [ADDR_W-1:0] LEN_L = ADDR_W'(LARGE_LEN);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  bank_st_e          bst_q [2];
  bank_st_e          bst_d [2];
  logic [ADDR_W-1:0] blen_q [2];
  logic [ADDR_W-1:0] blen_d [2];
  wr_st_e            wst_q, wst_d;
  rd_st_e            rdst_q, rdst_d;
  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] wlen_q, wlen_d;
  logic              last_wr_q, last_wr_d;
  logic              oldest_q, oldest_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] ridx_q, ridx_d;
  logic [ADDR_W-1:0] rlen_q, rlen_d;
  logic              perr_q, perr_d;
  logic              ov_q, ol_q, done_q;

  logic [1:0]        empty_c, full_c;
  logic              pick_c, rsel_c, close_c, rd_last_c;
  logic [ADDR_W-1:0] new_len_c, close_len_c;

  // Next-state for writer, reader and per-bank fill state
  always_comb begin
    bst_d       = bst_q;
    blen_d      = blen_q;
    wst_d       = wst_q;
    rdst_d      = rdst_q;
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    wlen_d      = wlen_q;
    last_wr_d   = last_wr_q;
    oldest_d    = oldest_q;
    rbank_d     = rbank_q;
    ridx_d      = ridx_q;
    rlen_d      = rlen_q;
    perr_d      = perr_q;
    close_c     = 1'b0;
    close_len_c = '0;
    rd_last_c   = 1'b0;
    in_ready_o  = 1'b0;
    wr_en_o     = 1'b0;
    wr_bank_o   = wbank_q;
    wr_idx_o    = '0;
    rd_en_o     = 1'b0;
    empty_c     = {bst_q[1] == B_EMPTY, bst_q[0] == B_EMPTY};
    full_c      = {bst_q[1] == B_FULL, bst_q[0] == B_FULL};
    pick_c      = (&empty_c) ? ~last_wr_q : ~empty_c[0];
    rsel_c      = (&full_c) ? oldest_q : ~full_c[0];
    new_len_c   = block_size_i ? LEN_L : LEN_S;

    case (wst_q)
      W_IDLE: begin
        in_ready_o = |empty_c;
        wr_bank_o  = pick_c;
        if (in_valid_i && in_ready_o) begin
          if (in_start_i) begin
            wr_en_o        = 1'b1;
            wbank_d        = pick_c;
            last_wr_d      = pick_c;
            wlen_d         = new_len_c;
            wcnt_d         = ONE;
            bst_d[pick_c]  = B_FILLING;
            wst_d          = W_FILL;
            if (in_end_i || new_len_c == ONE) begin
              close_c     = 1'b1;
              close_len_c = ONE;
            end
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      W_FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          wr_en_o = 1'b1;
          if (in_start_i) begin
            // restart discards the partial block but keeps the bank
            wlen_d = new_len_c;
            wcnt_d = ONE;
            if (in_end_i || new_len_c == ONE) begin
              close_c     = 1'b1;
              close_len_c = ONE;
            end
          end else begin
            wr_idx_o = wcnt_q;
            wcnt_d   = wcnt_q + ONE;
            if (in_end_i || wcnt_q == wlen_q - ONE) begin
              close_c     = 1'b1;
              close_len_c = wcnt_q + ONE;
            end
          end
        end
      end
      default: ;
    endcase

    if (in_valid_i && !in_ready_o) perr_d = 1'b1;

    if (close_c) begin
      bst_d[wbank_d]  = B_FULL;
      blen_d[wbank_d] = close_len_c;
      wst_d           = W_IDLE;
      if (bst_q[~wbank_d] != B_FULL) oldest_d = wbank_d;
    end

    case (rdst_q)
      R_IDLE: begin
        if (|full_c) begin
          bst_d[rsel_c] = B_DRAINING;
          rbank_d       = rsel_c;
          rlen_d        = blen_q[rsel_c];
          ridx_d        = '0;
          rdst_d        = R_READ;
        end
      end
      R_READ: begin
        rd_en_o = out_ready_i;
        if (rd_en_o) begin
          if (ridx_q == rlen_q - ONE) begin
            rd_last_c      = 1'b1;
            bst_d[rbank_q] = B_EMPTY;
            ridx_d         = '0;
            rdst_d         = R_IDLE;
          end else begin
            ridx_d = ridx_q + ONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bst_q     <= '{B_EMPTY, B_EMPTY};
      blen_q    <= '{'0, '0};
      wst_q     <= W_IDLE;
      rdst_q    <= R_IDLE;
      wbank_q   <= 1'b0;
      wcnt_q    <= '0;
      wlen_q    <= '0;
      last_wr_q <= 1'b1;
      oldest_q  <= 1'b0;
      rbank_q   <= 1'b0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      perr_q    <= 1'b0;
      ov_q      <= 1'b0;
      ol_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bst_q     <= bst_d;
      blen_q    <= blen_d;
      wst_q     <= wst_d;
      rdst_q    <= rdst_d;
      wbank_q   <= wbank_d;
      wcnt_q    <= wcnt_d;
      wlen_q    <= wlen_d;
      last_wr_q <= last_wr_d;
      oldest_q  <= oldest_d;
      rbank_q   <= rbank_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      perr_q    <= perr_d;
      ov_q      <= rd_en_o;
      ol_q      <= rd_last_c;
      done_q    <= rd_last_c;
    end
  end

  assign rd_bank_o   = rbank_q;
  assign rd_idx_o    = ridx_q;
  assign out_valid_o = ov_q;
  assign out_last_o  = ol_q;
  assign done_o      = done_q;
  assign proto_err_o = perr_q;
  assign bank_full_o = {(bst_q[1] == B_FULL) || (bst_q[1] == B_DRAINING),
                        (bst_q[0] == B_FULL) || (bst_q[0] == B_DRAINING)};

endmodule

// File: tb/tb_interleaver_bank_sched.sv
// Directed bench for interleaver_bank_sched: cycle table for the basic protocol, then
// hand sequences for full blocks, overflow, early end, restart, stall and reset.
module tb_interleaver_bank_sched;
  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          reset, bs, in_start, in_valid, in_end, out_ready;
  logic          in_ready, wr_en, wr_bank, rd_en, rd_bank;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          out_valid, out_last, done, proto_err;
  logic [1:0]    bank_full;

  int total = 0;
  int bad   = 0;

  interleaver_bank_sched dut (
    .clk_i(clk), .reset_i(reset), .block_size_i(bs), .in_start_i(in_start),
    .in_valid_i(in_valid), .in_end_i(in_end), .in_ready_o(in_ready),
    .wr_en_o(wr_en), .wr_bank_o(wr_bank), .wr_idx_o(wr_idx),
    .rd_en_o(rd_en), .rd_bank_o(rd_bank), .rd_idx_o(rd_idx),
    .out_ready_i(out_ready), .out_valid_o(out_valid), .out_last_o(out_last),
    .bank_full_o(bank_full), .done_o(done), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ir, we, wb;
    logic [AW-1:0] wi;
    logic          re, rb;
    logic [AW-1:0] ri;
    logic          ov, ol;
    logic [1:0]    bf;
    logic          dn, pe;
  } out_t;

  typedef struct {
    logic rst, bsz, st, vl, en, ord;
    out_t exp;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic rst, bsz, st, vl, en, ord,
                              input logic ir, we, wb, input int wi,
                              input logic re, rb, input int ri,
                              input logic ov, ol, input logic [1:0] bf,
                              input logic dn, pe);
    vec_t v;
    v.rst = rst; v.bsz = bsz; v.st = st; v.vl = vl; v.en = en; v.ord = ord;
    v.exp = {ir, we, wb, AW'(wi), re, rb, AW'(ri), ov, ol, bf, dn, pe};
    return v;
  endfunction

  function automatic out_t cur();
    return {in_ready, wr_en, wr_bank, wr_idx, rd_en, rd_bank, rd_idx,
            out_valid, out_last, bank_full, done, proto_err};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
    bs = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wbeat(input logic st, input logic en, input logic b,
                       input int exp_idx, input logic exp_bank);
    @(negedge clk);
    in_valid = 1'b1; in_start = st; in_end = en; bs = b;
    #1;
    chk("wr_beat", 64'({in_ready, wr_en, wr_bank, wr_idx}),
        64'({1'b1, 1'b1, exp_bank, AW'(exp_idx)}));
  endtask

  // Drains one block, checking index order, count, 1-cycle valid lag and last/done.
  task automatic drain(input int len, input bit toggle, input logic exp_bank);
    int   issued = 0;
    int   valids = 0;
    int   cyc    = 0;
    logic prev_rd = 1'b0;
    logic seen    = 1'b0;
    while (!seen && cyc < 3 * len + 20) begin
      @(negedge clk);
      in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      chk("ov_lag", 64'(out_valid), 64'(prev_rd));
      chk("done_eq", 64'(done), 64'(out_valid & out_last));
      if (out_valid) begin
        valids++;
        chk("last_pos", 64'(out_last), 64'(valids == len));
        seen = out_last;
      end
      if (rd_en) begin
        chk("rd_idx", 64'(rd_idx), 64'(issued));
        chk("rd_bank", 64'(rd_bank), 64'(exp_bank));
        issued++;
      end
      prev_rd = rd_en;
      cyc++;
    end
    chk("drain_end", 64'(seen), 64'(1));
    chk("rd_cnt", 64'(issued), 64'(len));
    chk("ov_cnt", 64'(valids), 64'(issued));
    chk("bf_clear", 64'(bank_full), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //              rst bs st vl en or | ir we wb wi re rb ri ov ol bf    dn pe
    vecs[0]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    vecs[1]  = mk(0, 0, 1, 1, 0, 1,   1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 1,   1, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 1,   1, 1, 0, 2, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 1, 1, 0, 2'b01, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 1, 0, 1, 0, 0, 2'b01, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 1,   1, 0, 1, 0, 1, 0, 2, 1, 0, 2'b01, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 0, 1, 1, 2'b00, 1, 1);
    vecs[10] = mk(0, 1, 1, 1, 1, 1,   1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00, 1, 1);
    vecs[15] = mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; bs = vecs[i].bsz; in_start = vecs[i].st;
      in_valid = vecs[i].vl; in_end = vecs[i].en; out_ready = vecs[i].ord;
      #1;
      chk($sformatf("vec%0d", i), 64'(cur()), 64'(vecs[i].exp));
    end

    // Full small block, reader at full rate
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 1056; i++) wbeat(i == 0, 1'b0, 1'b0, i, 1'b0);
    drain(1056, 1'b0, 1'b0);

    // Three large blocks with reader stalled: third block overflows
    do_reset();
    for (int i = 0; i < 6144; i++) wbeat(i == 0, 1'b0, 1'b1, i, 1'b0);
    for (int i = 0; i < 6144; i++) wbeat(i == 0, 1'b0, 1'b1, i, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_start = (i == 0); in_end = 1'b0; bs = 1'b1;
      #1;
      chk("ovf_ready", 64'({in_ready, wr_en}), 64'(0));
      if (i == 0) chk("ovf_perr_pre", 64'(proto_err), 64'(0));
      if (i == 1) chk("ovf_perr_set", 64'(proto_err), 64'(1));
    end
    chk("ovf_bf", 64'(bank_full), 64'(2'b11));
    chk("ovf_rd_en", 64'(rd_en), 64'(0));

    // Early in_end on beat 100 of a large block
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) wbeat(i == 0, i == 99, 1'b1, i, 1'b0);
    drain(100, 1'b0, 1'b0);

    // Restart at beat 500; only the restarted 20-beat block is read
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 500; i++) wbeat(i == 0, 1'b0, 1'b0, i, 1'b0);
    for (int i = 0; i < 20; i++) wbeat(i == 0, i == 19, 1'b1, i, 1'b0);
    drain(20, 1'b0, 1'b0);

    // Toggling out_ready
    do_reset();
    for (int i = 0; i < 40; i++) wbeat(i == 0, i == 39, 1'b0, i, 1'b0);
    drain(40, 1'b1, 1'b0);

    // Reset while one bank drains and the other fills
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_start = 1'b0; in_end = 1'b0;
    #1;
    chk("drop_no_start", 64'({in_ready, wr_en}), 64'(2'b10));
    for (int i = 0; i < 30; i++) wbeat(i == 0, i == 29, 1'b0, i, 1'b0);
    for (int i = 0; i < 20; i++) wbeat(i == 0, 1'b0, 1'b1, i, 1'b1);
    chk("mid_rd_en", 64'(rd_en), 64'(1));
    chk("mid_bf", 64'(bank_full), 64'(2'b01));
    chk("mid_perr", 64'(proto_err), 64'(1));
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_state", 64'({bank_full, in_ready, rd_en, wr_en, proto_err, out_valid}),
        64'(7'b0010000));
    @(negedge clk);
    #1;
    chk("rst_quiet", 64'({bank_full, rd_en, out_valid}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
